// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM that steps the processor datapath through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over several cycles.
// It latches the decoded opcode, drives the datapath enables, runs a
// bounded req/ack handshake with data memory, counts retired
// instructions, and traps into HALT on an illegal opcode or on a
// memory timeout.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   run          in   permits starting / continuing sequencing
//   opcode[6:0]  in   opcode from decode unit, sampled in DECODE
//   branch       in   branch condition, sampled in EXEC
//   mem_ack      in   data-memory completion strobe (used only in MEM)
//   ir_en        out  latch instruction register (FETCH)
//   pc_en        out  advance PC; one pulse per retired instruction
//   branch_take  out  PC loads branch target instead of PC+4
//   rf_wen       out  register-file write enable (WB)
//   mem_req      out  data-memory request (MEM)
//   mem_we       out  data-memory write, stores only
//   state[2:0]   out  current FSM state
//   illegal      out  sticky illegal-opcode flag
//   timeout      out  sticky memory-timeout flag
//   instr_count  out  retired-instruction counter, wraps silently
//
// The strobes are combinational decodes of the registered state, the
// latched opcode and branch/mem_ack, so they are valid in the same
// cycle as the state that produces them.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int COUNT_W     = 32,
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic               branch,
    input  logic               mem_ack,
    output logic               ir_en,
    output logic               pc_en,
    output logic               branch_take,
    output logic               rf_wen,
    output logic               mem_req,
    output logic               mem_we,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               timeout,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Wait-counter value seen during the last MEM cycle before a timeout.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    function automatic logic is_alu(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return is_alu(op) || is_mem(op) || (op == OP_BRANCH);
    endfunction

    logic [2:0]           state_r;
    logic [2:0]           next_s;
    logic [6:0]           op_q_r;
    logic [TIMEOUT_W-1:0] wait_r;
    logic [COUNT_W-1:0]   instr_count_r;
    logic                 illegal_r;
    logic                 timeout_r;

    logic                 ir_en_s;
    logic                 pc_en_s;
    logic                 branch_take_s;
    logic                 rf_wen_s;
    logic                 mem_req_s;
    logic                 mem_we_s;
    logic                 illegal_set_s;
    logic                 timeout_set_s;
    logic                 wait_last_s;

    assign wait_last_s = (wait_r == WAIT_LAST);

    // Next-state and strobe decode from the registered state.
    always_comb begin
        next_s        = state_r;
        ir_en_s       = 1'b0;
        pc_en_s       = 1'b0;
        branch_take_s = 1'b0;
        rf_wen_s      = 1'b0;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        illegal_set_s = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_en_s = 1'b1;
                next_s  = S_DECODE;
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    next_s = S_EXEC;
                end else begin
                    illegal_set_s = 1'b1;
                    next_s        = S_HALT;
                end
            end
            S_EXEC: begin
                if (op_q_r == OP_BRANCH) begin
                    // Branches retire here; there is no WB for them.
                    pc_en_s       = 1'b1;
                    branch_take_s = branch;
                    if (run) begin
                        next_s = S_FETCH;
                    end else begin
                        next_s = S_IDLE;
                    end
                end else if (is_mem(op_q_r)) begin
                    next_s = S_MEM;
                end else if (is_alu(op_q_r)) begin
                    next_s = S_WB;
                end else begin
                    // op_q_r only holds legal opcodes; fail safe if it does not.
                    next_s = S_HALT;
                end
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                mem_we_s  = (op_q_r == OP_STORE);
                // Ack wins even in the cycle the wait would expire.
                if (mem_ack) begin
                    if (op_q_r == OP_STORE) begin
                        pc_en_s = 1'b1;
                        if (run) begin
                            next_s = S_FETCH;
                        end else begin
                            next_s = S_IDLE;
                        end
                    end else begin
                        next_s = S_WB;
                    end
                end else if (wait_last_s) begin
                    timeout_set_s = 1'b1;
                    next_s        = S_HALT;
                end else begin
                    next_s = S_MEM;
                end
            end
            S_WB: begin
                rf_wen_s = 1'b1;
                pc_en_s  = 1'b1;
                if (run) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_HALT: begin
                next_s = S_HALT;
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Opcode latch; held from DECODE until the next DECODE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q_r <= 7'd0;
        end else if (state_r == S_DECODE) begin
            op_q_r <= opcode;
        end else begin
            op_q_r <= op_q_r;
        end
    end

    // Memory wait counter: cleared on the way into MEM, counts ack-less MEM cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_r <= {TIMEOUT_W{1'b0}};
        end else if (state_r == S_EXEC) begin
            wait_r <= {TIMEOUT_W{1'b0}};
        end else if ((state_r == S_MEM) && !mem_ack) begin
            wait_r <= wait_r + TIMEOUT_W'(1);
        end else begin
            wait_r <= wait_r;
        end
    end

    // Sticky trap flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | illegal_set_s;
            timeout_r <= timeout_r | timeout_set_s;
        end
    end

    // Retired-instruction counter, one count per pc_en pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count_r <= {COUNT_W{1'b0}};
        end else if (pc_en_s) begin
            instr_count_r <= instr_count_r + COUNT_W'(1);
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    assign ir_en       = ir_en_s;
    assign pc_en       = pc_en_s;
    assign branch_take = branch_take_s;
    assign rf_wen      = rf_wen_s;
    assign mem_req     = mem_req_s;
    assign mem_we      = mem_we_s;
    assign state       = state_r;
    assign illegal     = illegal_r;
    assign timeout     = timeout_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Each instruction is expanded into the cycle-by-cycle trace the
// controller must produce (state number, strobes, flags) together with
// the inputs to drive in each cycle; inputs that must be ignored in a
// given cycle are randomised. Table rows and random rows go through the
// same expansion; trap and reset corner cases are hand sequences.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam int         MEM_TIMEOUT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        branch = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ir_en, pc_en, branch_take, rf_wen, mem_req, mem_we;
    logic [2:0]  state;
    logic        illegal, timeout;
    logic [31:0] instr_count;

    multicycle_controller #(
        .COUNT_W    (32),
        .TIMEOUT_W  (4),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .branch     (branch),
        .mem_ack    (mem_ack),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .branch_take(branch_take),
        .rf_wen     (rf_wen),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .state      (state),
        .illegal    (illegal),
        .timeout    (timeout),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // One cycle: inputs to drive and outputs required.
    typedef struct {
        logic [6:0] op;
        logic       br;
        logic       ack;
        logic       run;
        logic [2:0] st;
        logic       ir, pc, bt, rf, rq, we, ill, to;
    } cyc_t;

    // One instruction row: inputs plus required FETCH..retire latency.
    typedef struct {
        logic [6:0] op;
        logic       br;
        int         n;
        logic       rm;
        logic       re;
        int         lat;
    } vec_t;

    cyc_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic        m_idle = 1'b1;
    logic [31:0] m_cnt = 32'd0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic int spec_lat(input logic [6:0] op, input int n);
        if (op == OP_BR) return 3;
        if (op == OP_ST) return 4 + n;
        if (op == OP_LD) return 5 + n;
        return 4;
    endfunction

    // Cycle with all strobes low and the ignored inputs randomised.
    function automatic cyc_t blank(input logic [2:0] st, input logic rn);
        cyc_t c;
        c.op  = 7'($urandom);
        c.br  = 1'($urandom);
        c.ack = 1'($urandom);
        c.run = rn;
        c.st  = st;
        c.ir  = 1'b0; c.pc = 1'b0; c.bt = 1'b0; c.rf = 1'b0;
        c.rq  = 1'b0; c.we = 1'b0; c.ill = 1'b0; c.to = 1'b0;
        return c;
    endfunction

    // Expand one instruction into its required trace.
    // n = ack-less MEM cycles; ack_ok = 0 means ack never comes.
    task automatic build(input logic [6:0] op, input logic br, input int n,
                         input logic ack_ok, input logic rm, input logic re);
        cyc_t c;
        logic legal;
        legal = (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
                (op == OP_ST) || (op == OP_BR);
        q.delete();
        if (m_idle) begin
            for (int g = 0; g < $urandom_range(0, 2); g++) q.push_back(blank(3'd0, 1'b0));
            q.push_back(blank(3'd0, 1'b1));
        end
        c = blank(3'd1, rm); c.ir = 1'b1; q.push_back(c);
        c = blank(3'd2, rm); c.op = op;   q.push_back(c);
        if (!legal) begin
            for (int k = 0; k < 20; k++) begin
                c = blank(3'd6, 1'b1); c.ill = 1'b1; q.push_back(c);
            end
            return;
        end
        if (op == OP_BR) begin
            c = blank(3'd3, re); c.br = br; c.pc = 1'b1; c.bt = br; q.push_back(c);
        end else if (op == OP_R || op == OP_I) begin
            q.push_back(blank(3'd3, rm));
            c = blank(3'd5, re); c.rf = 1'b1; c.pc = 1'b1; q.push_back(c);
        end else begin
            q.push_back(blank(3'd3, rm));
            for (int k = 0; k < n; k++) begin
                c = blank(3'd4, rm); c.ack = 1'b0; c.rq = 1'b1; c.we = (op == OP_ST);
                q.push_back(c);
            end
            if (!ack_ok) begin
                for (int k = 0; k < 5; k++) begin
                    c = blank(3'd6, 1'b1); c.ack = 1'b0; c.to = 1'b1; q.push_back(c);
                end
                return;
            end
            c = blank(3'd4, (op == OP_ST) ? re : rm);
            c.ack = 1'b1; c.rq = 1'b1; c.we = (op == OP_ST); c.pc = (op == OP_ST);
            q.push_back(c);
            if (op == OP_LD) begin
                c = blank(3'd5, re); c.rf = 1'b1; c.pc = 1'b1; q.push_back(c);
            end
        end
        m_idle = !re;
    endtask

    // Drive the trace, compare every cycle, measure latency, check the count.
    task automatic apply(input string nm, input int exp_lat);
        int   cnt = 0;
        int   meas = -1;
        logic started = 1'b0;
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; branch = q[i].br; mem_ack = q[i].ack; run = q[i].run;
            #1;
            chk(nm, {state, ir_en, pc_en, branch_take, rf_wen, mem_req, mem_we, illegal, timeout},
                {q[i].st, q[i].ir, q[i].pc, q[i].bt, q[i].rf, q[i].rq, q[i].we, q[i].ill, q[i].to});
            if (q[i].pc) m_cnt = m_cnt + 32'd1;
            if (!started && state == 3'd1) started = 1'b1;
            if (started) cnt++;
            if (started && pc_en && meas < 0) meas = cnt;
        end
        if (exp_lat >= 0) chk({nm, " latency"}, 64'(meas), 64'(exp_lat));
        @(posedge clk); #1;
        chk({nm, " count"}, instr_count, m_cnt);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; mem_ack = 1'b0; branch = 1'b0; opcode = 7'd0;
        #1;
        chk({nm, " in reset"}, {state, ir_en, pc_en, branch_take, rf_wen, mem_req, mem_we,
                                illegal, timeout, instr_count}, 64'd0);
        @(posedge clk); #1;
        chk({nm, " reset held"}, {state, ir_en, pc_en, mem_req, illegal, timeout, instr_count},
            64'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        m_idle = 1'b1;
        m_cnt  = 32'd0;
    endtask

    vec_t tbl[10];

    initial begin
        //            op     br    n   rm    re    lat
        tbl[0] = '{OP_R,  1'b0, 0,  1'b1, 1'b1, 4};   // R-type after reset
        tbl[1] = '{OP_LD, 1'b0, 2,  1'b1, 1'b1, 7};   // ack in 3rd MEM cycle
        tbl[2] = '{OP_ST, 1'b0, 0,  1'b1, 1'b1, 4};   // ack in 1st MEM cycle
        tbl[3] = '{OP_BR, 1'b1, 0,  1'b1, 1'b1, 3};   // taken branch
        tbl[4] = '{OP_BR, 1'b0, 0,  1'b1, 1'b1, 3};   // not-taken branch
        tbl[5] = '{OP_R,  1'b0, 0,  1'b0, 1'b0, 4};   // run dropped mid-instr
        tbl[6] = '{OP_I,  1'b0, 0,  1'b1, 1'b1, 4};   // restart from IDLE
        tbl[7] = '{OP_LD, 1'b0, 11, 1'b1, 1'b1, 16};  // ack on the last allowed cycle
        tbl[8] = '{OP_ST, 1'b0, 11, 1'b1, 1'b0, 15};
        tbl[9] = '{OP_ST, 1'b0, 3,  1'b0, 1'b1, 7};

        do_reset("reset");

        foreach (tbl[i]) begin
            build(tbl[i].op, tbl[i].br, tbl[i].n, 1'b1, tbl[i].rm, tbl[i].re);
            apply($sformatf("row%0d", i), tbl[i].lat);
        end

        for (int r = 0; r < 60; r++) begin
            logic [6:0] op;
            int         n;
            case ($urandom_range(0, 4))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_ST;
                default: op = OP_BR;
            endcase
            n = $urandom_range(0, MEM_TIMEOUT - 1);
            build(op, 1'($urandom), n, 1'b1, 1'($urandom), 1'($urandom));
            apply($sformatf("rand%0d", r), spec_lat(op, n));
        end

        // Illegal opcode: HALT, no more fetches, reset clears the flag.
        build(7'b1111111, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        apply("illegal", -1);
        do_reset("after illegal");

        // LOAD with no ack: HALT after MEM_TIMEOUT MEM cycles.
        build(OP_LD, 1'b0, MEM_TIMEOUT, 1'b0, 1'b1, 1'b1);
        apply("timeout", -1);
        do_reset("after timeout");

        // Reset asserted mid-MEM takes effect before the next clock edge.
        build(OP_LD, 1'b0, 6, 1'b1, 1'b1, 1'b1);
        begin
            int k = 0;
            int mems = 0;
            while (mems < 2) begin
                if (q[k].st == 3'd4) mems++;
                k++;
            end
            while (q.size() > k) void'(q.pop_back());
        end
        apply("midmem", -1);
        chk("midmem still MEM", {state, mem_req}, {3'd4, 1'b1});
        rst = 1'b0;
        #1;
        chk("midmem async reset", {state, mem_req, mem_we, rf_wen, pc_en, ir_en}, 64'd0);
        do_reset("after midmem");

        // Back to normal operation after all the traps.
        build(OP_BR, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        apply("final branch", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
